// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit processor.
// Sequences fetch/decode/execute/memory/write-back with a bounded memory wait.
module multicycle_control #(
    parameter int unsigned MEM_WAIT_MAX = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic [2:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  PCSource,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [3:0]  state,
    output logic [15:0] instr_count,
    output logic        halted,
    output logic        illegal_op,
    output logic        mem_timeout
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
    } ctl_t;

    localparam logic [15:0] LP_LAST  = 16'(MEM_WAIT_MAX - 1);
    localparam bit          LP_TO_EN = (MEM_WAIT_MAX != 0);

    state_t      r_state;
    state_t      w_next;
    ctl_t        r_ctl;
    logic [15:0] r_wait;
    logic [15:0] r_count;
    logic        r_illegal;
    logic        r_timeout;
    logic        w_stay;
    logic        w_retire;
    logic        w_set_ill;
    logic        w_set_to;
    logic        w_expired;
    logic        w_fetch_rdy;
    logic        w_unused;

    // funct goes to ALU control and zero to the PC gate; neither steers the FSM
    assign w_unused    = ^{funct, zero};
    assign w_expired   = LP_TO_EN && !mem_ready && (r_wait == LP_LAST);
    assign w_fetch_rdy = (r_state == S_FETCH) && mem_ready;

    // Moore control word for the state being entered
    function automatic ctl_t f_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_WB_I: c.reg_write = 1'b1;
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // next-state selection, wait/retire/flag events
    always_comb begin
        w_next    = r_state;
        w_stay    = 1'b0;
        w_retire  = 1'b0;
        w_set_ill = 1'b0;
        w_set_to  = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    if (r_state == S_FETCH) begin
                        w_next = S_DECODE;
                    end else if (r_state == S_MEM_RD) begin
                        w_next = S_WB_MEM;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_expired) begin
                    w_next   = S_HALT;
                    w_set_to = 1'b1;
                end else begin
                    w_stay = 1'b1;
                end
            end
            S_DECODE: begin
                unique case (opcode)
                    4'h0:       w_next = S_EXEC_R;
                    4'h1:       w_next = S_EXEC_I;
                    4'h2, 4'h3: w_next = S_MEM_ADDR;
                    4'h4:       w_next = S_BRANCH;
                    4'h5:       w_next = S_JUMP;
                    4'hF:       w_next = S_HALT;
                    default: begin
                        w_next    = S_HALT;
                        w_set_ill = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (opcode == 4'h3) ? S_MEM_WR : S_MEM_RD;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // state, registered controls, wait counter, retire counter, sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ctl     <= '0;
            r_wait    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctl   <= f_ctl(w_next);
            r_wait  <= w_stay ? r_wait + 16'd1 : 16'd0;
            if (w_retire) begin
                r_count <= r_count + 16'd1;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
            if (w_set_to) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign PCWrite     = r_ctl.pc_write | w_fetch_rdy;
    assign PCWriteCond = r_ctl.pc_write_cond;
    assign PCSource    = r_ctl.pc_source;
    assign IRWrite     = w_fetch_rdy;
    assign IorD        = r_ctl.iord;
    assign MemRead     = r_ctl.mem_read;
    assign MemWrite    = r_ctl.mem_write;
    assign MemtoReg    = r_ctl.mem_to_reg;
    assign RegWrite    = r_ctl.reg_write;
    assign RegDst      = r_ctl.reg_dst;
    assign ALUSrcA     = r_ctl.alu_src_a;
    assign ALUSrcB     = r_ctl.alu_src_b;
    assign ALUOp       = r_ctl.alu_op;
    assign halted      = r_ctl.halted;
    assign state       = r_state;
    assign instr_count = r_count;
    assign illegal_op  = r_illegal;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected state traces
// built from opcode latencies and wait rules, checked every cycle.
module tb_multicycle_control;

    localparam int MAXW = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic [2:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IRWrite, IorD, MemRead, MemWrite;
    logic        MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]  PCSource, ALUSrcB, ALUOp;
    logic [3:0]  state;
    logic [15:0] instr_count;
    logic        halted, illegal_op, mem_timeout;
    logic [16:0] w_dut;

    multicycle_control #(.MEM_WAIT_MAX(MAXW)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state),
        .instr_count(instr_count), .halted(halted), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout)
    );

    always #5 clock = ~clock;

    assign w_dut = {PCWrite, PCWriteCond, PCSource, IRWrite, IorD, MemRead,
                    MemWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB,
                    ALUOp, halted};

    typedef struct {
        int          st;
        bit          mr;
        logic [15:0] cnt;
        bit          ill;
        bit          to;
    } exp_t;

    exp_t        q[$];
    exp_t        ce;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_count;
    bit          m_ill;
    bit          m_to;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // control word each state must show, straight from the state action table
    function automatic logic [16:0] exp_ctl(int st, bit mr);
        logic pcw = 0, pcc = 0, irw = 0, iord = 0, mrd = 0, mwr = 0;
        logic m2r = 0, rw = 0, rd = 0, asa = 0, hlt = 0;
        logic [1:0] pcs = 0, asb = 0, aop = 0;
        case (st)
            1: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            2: asb = 2'b11;
            3: begin asa = 1; aop = 2'b10; end
            4: begin rw = 1; rd = 1; end
            5, 7: begin asa = 1; asb = 2'b10; end
            6: rw = 1;
            8: begin mrd = 1; iord = 1; end
            9: begin rw = 1; m2r = 1; end
            10: begin mwr = 1; iord = 1; end
            11: begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
            12: begin pcw = 1; pcs = 2'b10; end
            13: hlt = 1;
            default: ;
        endcase
        return {pcw, pcc, pcs, irw, iord, mrd, mwr, m2r, rw, rd, asa, asb, aop, hlt};
    endfunction

    always @(negedge clock) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            chk("state", 32'(state), 32'(ce.st));
            chk("controls", 32'(w_dut), 32'(exp_ctl(ce.st, ce.mr)));
            chk("instr_count", 32'(instr_count), 32'(ce.cnt));
            chk("flags", 32'({illegal_op, mem_timeout}), 32'({ce.ill, ce.to}));
        end
    end

    task automatic push(int st, bit mr);
        exp_t e;
        mem_ready = mr;
        e.st  = st;
        e.mr  = mr;
        e.cnt = m_count;
        e.ill = m_ill;
        e.to  = m_to;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic any(int st);
        push(st, 1'($urandom_range(0, 1)));
    endtask

    task automatic wait_seg(int st, int waits, output bit hit);
        hit = 1'b0;
        if (waits >= MAXW) begin
            repeat (MAXW) push(st, 1'b0);
            m_to = 1'b1;
            hit  = 1'b1;
        end else begin
            repeat (waits) push(st, 1'b0);
            push(st, 1'b1);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        m_count = '0;
        m_ill   = 1'b0;
        m_to    = 1'b0;
        any(0);
        reset = 1'b0;
        any(0);
    endtask

    task automatic run(logic [3:0] op, int fw, int mw, bit z);
        bit hit;
        opcode = op;
        zero   = z;
        funct  = 3'($urandom);
        wait_seg(1, fw, hit);
        if (hit) begin
            repeat (3) any(13);
            return;
        end
        any(2);
        case (op)
            4'h0: begin any(3); any(4); m_count++; end
            4'h1: begin any(5); any(6); m_count++; end
            4'h2: begin
                any(7);
                wait_seg(8, mw, hit);
                if (hit) begin
                    repeat (3) any(13);
                    return;
                end
                any(9);
                m_count++;
            end
            4'h3: begin
                any(7);
                wait_seg(10, mw, hit);
                if (hit) begin
                    repeat (3) any(13);
                    return;
                end
                m_count++;
            end
            4'h4: begin any(11); m_count++; end
            4'h5: begin any(12); m_count++; end
            default: begin
                if (op != 4'hF) m_ill = 1'b1;
                repeat (4) any(13);
            end
        endcase
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 4'h0;
        funct     = 3'h0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        m_count   = '0;
        m_ill     = 1'b0;
        m_to      = 1'b0;
        do_reset();
        run(4'h0, 0, 0, 1'b0);
        chk("count_after_r", 32'(instr_count), 32'd1);
        run(4'h2, 0, 3, 1'b0);
        chk("count_after_lw", 32'(instr_count), 32'd2);
        run(4'h4, 0, 0, 1'b1);
        run(4'h4, 0, 0, 1'b0);
        chk("count_after_beq", 32'(instr_count), 32'd4);
        run(4'h1, 2, 0, 1'b0);
        run(4'h3, 0, 2, 1'b0);
        run(4'h5, 0, 0, 1'b0);
        chk("count_after_mix", 32'(instr_count), 32'd7);
        run(4'h0, MAXW - 1, 0, 1'b0);
        run(4'h2, 0, MAXW - 1, 1'b0);
        chk("count_edge_wait", 32'(instr_count), 32'd9);
        chk("no_timeout_edge", 32'(mem_timeout), 32'd0);
        opcode = 4'h0;
        push(1, 1'b1);
        any(2);
        any(3);
        do_reset();
        chk("count_after_abort", 32'(instr_count), 32'd0);
        run(4'h7, 0, 0, 1'b0);
        chk("illegal_halt", 32'({halted, illegal_op, state}), 32'h3D);
        do_reset();
        chk("illegal_cleared", 32'({halted, illegal_op}), 32'd0);
        run(4'h0, MAXW, 0, 1'b0);
        chk("fetch_timeout", 32'({halted, mem_timeout, state}), 32'h3D);
        do_reset();
        run(4'h3, 0, MAXW + 1, 1'b0);
        chk("memwr_timeout", 32'({mem_timeout, instr_count}), 32'h10000);
        do_reset();
        run(4'hF, 0, 0, 1'b0);
        chk("halt_opcode", 32'({halted, illegal_op, mem_timeout}), 32'd4);
        chk("halt_not_counted", 32'(instr_count), 32'd0);
        @(negedge clock);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
